// File: rtl/exu_lsu_if.sv
// EXU <-> LSU <-> memory <-> WBU signal bundle for the load/store unit.
// The slave modport is the LSU view; the master modport is the surrounding pipeline/memory.
interface exu_lsu_if #(
    parameter int unsigned ISA_WIDTH      = 32,
    parameter int unsigned MEM_MASK_WIDTH = ISA_WIDTH / 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_store;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [ISA_WIDTH-1:0]      req_addr;
    logic [ISA_WIDTH-1:0]      req_wdata;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [ISA_WIDTH-1:0]      mem_addr;
    logic                      mem_w_en;
    logic                      mem_r_en;
    logic [MEM_MASK_WIDTH-1:0] mem_mask;
    logic [ISA_WIDTH-1:0]      mem_w;
    logic                      mem_rvalid;
    logic [ISA_WIDTH-1:0]      mem_r;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ISA_WIDTH-1:0]      rsp_rdata;
    logic                      rsp_misalign;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_valid, mem_addr, mem_w_en, mem_r_en, mem_mask, mem_w,
        input  mem_ready, mem_rvalid, mem_r,
        output rsp_valid, rsp_rdata, rsp_misalign,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_valid, mem_addr, mem_w_en, mem_r_en, mem_mask, mem_w,
        output mem_ready, mem_rvalid, mem_r,
        input  rsp_valid, rsp_rdata, rsp_misalign,
        output rsp_ready
    );
endinterface

// File: rtl/exu_lsu.sv
// Single-outstanding load/store unit: aligns store data/masks, issues one memory
// request per op, extends load data, and short-circuits misaligned accesses.
module exu_lsu #(
    parameter int unsigned ISA_WIDTH      = 32,
    parameter int unsigned MEM_MASK_WIDTH = ISA_WIDTH / 8,
    parameter int unsigned OFF_WIDTH      = $clog2(MEM_MASK_WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    exu_lsu_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e state, state_nxt;

    // Byte-lane pattern for an access of 1 << size bytes
    function automatic logic [7:0] lane_bits(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] align_bits(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    logic [OFF_WIDTH-1:0] off_in;
    logic                 misalign_in;

    assign off_in      = bus.req_addr[OFF_WIDTH-1:0];
    assign misalign_in = ((3'(off_in) & align_bits(bus.req_size)) != 3'd0) ||
                         ((bus.req_size == 2'd3) && (ISA_WIDTH < 64));

    // Op attributes kept for the response phase
    logic                 st_q;
    logic                 uns_q;
    logic [1:0]           size_q;
    logic [OFF_WIDTH-1:0] off_q;

    logic                      req_ready_q,    req_ready_d;
    logic                      mem_valid_q,    mem_valid_d;
    logic [ISA_WIDTH-1:0]      mem_addr_q,     mem_addr_d;
    logic                      mem_w_en_q,     mem_w_en_d;
    logic                      mem_r_en_q,     mem_r_en_d;
    logic [MEM_MASK_WIDTH-1:0] mem_mask_q,     mem_mask_d;
    logic [ISA_WIDTH-1:0]      mem_w_q,        mem_w_d;
    logic                      rsp_valid_q,    rsp_valid_d;
    logic [ISA_WIDTH-1:0]      rsp_rdata_q,    rsp_rdata_d;
    logic                      rsp_misalign_q, rsp_misalign_d;

    // Load lane extraction and sign/zero extension
    logic [ISA_WIDTH-1:0] lane;
    logic [ISA_WIDTH-1:0] load_ext;

    assign lane = bus.mem_r >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = uns_q ? ISA_WIDTH'(lane[7:0])  : ISA_WIDTH'($signed(lane[7:0]));
            2'd1:    load_ext = uns_q ? ISA_WIDTH'(lane[15:0]) : ISA_WIDTH'($signed(lane[15:0]));
            2'd2:    load_ext = uns_q ? ISA_WIDTH'(lane[31:0]) : ISA_WIDTH'($signed(lane[31:0]));
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.req_valid) state_nxt = misalign_in ? S_RESP : S_REQ;
            S_REQ:  if (bus.mem_ready)  state_nxt = S_WAIT;
            S_WAIT: if (bus.mem_rvalid) state_nxt = S_RESP;
            S_RESP: if (bus.rsp_ready)  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a handshake moves it
    always_comb begin
        req_ready_d    = (state_nxt == S_IDLE);
        mem_valid_d    = mem_valid_q;
        mem_addr_d     = mem_addr_q;
        mem_w_en_d     = mem_w_en_q;
        mem_r_en_d     = mem_r_en_q;
        mem_mask_d     = mem_mask_q;
        mem_w_d        = mem_w_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_misalign_d = rsp_misalign_q;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (misalign_in) begin
                        rsp_valid_d    = 1'b1;
                        rsp_misalign_d = 1'b1;
                        rsp_rdata_d    = '0;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_w_en_d  = bus.req_store;
                        mem_r_en_d  = !bus.req_store;
                        mem_addr_d  = {bus.req_addr[ISA_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
                        mem_mask_d  = MEM_MASK_WIDTH'(lane_bits(bus.req_size)) << off_in;
                        mem_w_d     = bus.req_wdata << {off_in, 3'b000};
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_w_en_d  = 1'b0;
                    mem_r_en_d  = 1'b0;
                    mem_addr_d  = '0;
                    mem_mask_d  = '0;
                    mem_w_d     = '0;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    rsp_valid_d    = 1'b1;
                    rsp_misalign_d = 1'b0;
                    rsp_rdata_d    = st_q ? '0 : load_ext;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d    = 1'b0;
                    rsp_misalign_d = 1'b0;
                    rsp_rdata_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q           <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'd0;
            off_q          <= '0;
            req_ready_q    <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_w_en_q     <= 1'b0;
            mem_r_en_q     <= 1'b0;
            mem_mask_q     <= '0;
            mem_w_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_misalign_q <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req_valid) begin
                st_q   <= bus.req_store;
                uns_q  <= bus.req_unsigned;
                size_q <= bus.req_size;
                off_q  <= off_in;
            end
            req_ready_q    <= req_ready_d;
            mem_valid_q    <= mem_valid_d;
            mem_addr_q     <= mem_addr_d;
            mem_w_en_q     <= mem_w_en_d;
            mem_r_en_q     <= mem_r_en_d;
            mem_mask_q     <= mem_mask_d;
            mem_w_q        <= mem_w_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_w_en     = mem_w_en_q;
    assign bus.mem_r_en     = mem_r_en_q;
    assign bus.mem_mask     = mem_mask_q;
    assign bus.mem_w        = mem_w_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_misalign = rsp_misalign_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu: drives a 32-bit and a 64-bit instance through one shared
// stimulus path and scores memory requests and responses against a byte-level model.
module tb_exu_lsu;

    typedef struct {
        logic [63:0] addr;
        logic        w_en;
        logic        r_en;
        logic [7:0]  mask;
        logic [63:0] w;
    } mem_exp_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exu_lsu_if #(.ISA_WIDTH(32)) i32 ();
    exu_lsu_if #(.ISA_WIDTH(64)) i64 ();

    exu_lsu #(.ISA_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(i32));
    exu_lsu #(.ISA_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(i64));

    // Shared drive signals, steered to one instance by sel64
    logic        sel64 = 1'b0;
    logic        d_req_valid = 1'b0, d_store = 1'b0, d_uns = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic [63:0] d_addr = '0, d_wdata = '0, d_mem_r = '0;
    logic        d_mem_ready = 1'b0, d_mem_rvalid = 1'b0, d_rsp_ready = 1'b0;

    assign i32.req_valid    = d_req_valid & ~sel64;
    assign i32.req_store    = d_store;
    assign i32.req_size     = d_size;
    assign i32.req_unsigned = d_uns;
    assign i32.req_addr     = d_addr[31:0];
    assign i32.req_wdata    = d_wdata[31:0];
    assign i32.mem_ready    = d_mem_ready & ~sel64;
    assign i32.mem_rvalid   = d_mem_rvalid & ~sel64;
    assign i32.mem_r        = d_mem_r[31:0];
    assign i32.rsp_ready    = d_rsp_ready & ~sel64;

    assign i64.req_valid    = d_req_valid & sel64;
    assign i64.req_store    = d_store;
    assign i64.req_size     = d_size;
    assign i64.req_unsigned = d_uns;
    assign i64.req_addr     = d_addr;
    assign i64.req_wdata    = d_wdata;
    assign i64.mem_ready    = d_mem_ready & sel64;
    assign i64.mem_rvalid   = d_mem_rvalid & sel64;
    assign i64.mem_r        = d_mem_r;
    assign i64.rsp_ready    = d_rsp_ready & sel64;

    logic        o_req_ready, o_mem_valid, o_mem_w_en, o_mem_r_en, o_rsp_valid, o_rsp_misalign;
    logic [63:0] o_mem_addr, o_mem_w, o_rsp_rdata;
    logic [7:0]  o_mem_mask;

    assign o_req_ready    = sel64 ? i64.req_ready    : i32.req_ready;
    assign o_mem_valid    = sel64 ? i64.mem_valid    : i32.mem_valid;
    assign o_mem_w_en     = sel64 ? i64.mem_w_en     : i32.mem_w_en;
    assign o_mem_r_en     = sel64 ? i64.mem_r_en     : i32.mem_r_en;
    assign o_mem_addr     = sel64 ? i64.mem_addr     : {32'h0, i32.mem_addr};
    assign o_mem_mask     = sel64 ? i64.mem_mask     : {4'h0, i32.mem_mask};
    assign o_mem_w        = sel64 ? i64.mem_w        : {32'h0, i32.mem_w};
    assign o_rsp_valid    = sel64 ? i64.rsp_valid    : i32.rsp_valid;
    assign o_rsp_rdata    = sel64 ? i64.rsp_rdata    : {32'h0, i32.rsp_rdata};
    assign o_rsp_misalign = sel64 ? i64.rsp_misalign : i32.rsp_misalign;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-level reference for one access
    function automatic void model(input bit w64, input bit st, input bit uns, input logic [1:0] sz,
                                  input logic [63:0] addr_in, input logic [63:0] wd,
                                  input logic [63:0] mr, output mem_exp_t m, output rsp_exp_t r);
        int nb, off, by;
        logic [63:0] addr, v;
        addr = w64 ? addr_in : {32'h0, addr_in[31:0]};
        nb   = w64 ? 8 : 4;
        off  = int'(addr % 64'(nb));
        by   = 1 << sz;
        r.mis   = ((addr % 64'(by)) != 64'd0) || (sz == 2'd3 && !w64);
        r.rdata = '0;
        m.addr  = addr - 64'(off);
        m.w_en  = st;
        m.r_en  = !st;
        m.mask  = '0;
        m.w     = '0;
        for (int i = 0; i < by; i++) if (off + i < nb) m.mask[off+i] = 1'b1;
        for (int i = 0; i < nb - off; i++) m.w[8*(off+i) +: 8] = wd[8*i +: 8];
        if (!r.mis && !st) begin
            v = '0;
            for (int i = 0; i < by; i++) v[8*i +: 8] = mr[8*(off+i) +: 8];
            if (!uns && v[8*by-1]) for (int i = by; i < 8; i++) v[8*i +: 8] = 8'hFF;
            if (!w64) v[63:32] = 32'h0;
            r.rdata = v;
        end
    endfunction

    task automatic do_op(input bit w64, input bit st, input bit uns, input logic [1:0] sz,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] mr,
                         input int mdly, input int rdly, input bit early_rv);
        mem_exp_t m, me;
        rsp_exp_t r, re;
        int n;
        model(w64, st, uns, sz, addr, wd, mr, m, r);
        if (!r.mis) mem_q.push_back(m);
        rsp_q.push_back(r);
        @(negedge clk);
        sel64 = w64; d_store = st; d_uns = uns; d_size = sz;
        d_addr = addr; d_wdata = wd; d_mem_r = mr; d_req_valid = 1'b1;
        n = 0;
        while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
        check_eq("req_accept", 64'(n < 20), 64'd1);
        @(negedge clk);
        d_req_valid = 1'b0;
        check_eq("req_ready_busy", 64'(o_req_ready), 64'd0);
        if (!r.mis) begin
            check_eq("mem_valid_lat", 64'(o_mem_valid), 64'd1);
            me = mem_q.pop_front();
            for (int k = 0; k <= mdly; k++) begin
                check_eq("mem_valid_hold", 64'(o_mem_valid), 64'd1);
                check_eq("mem_addr", o_mem_addr, me.addr);
                check_eq("mem_mask", 64'(o_mem_mask), 64'(me.mask));
                check_eq("mem_w", o_mem_w, me.w);
                check_eq("mem_w_en", 64'(o_mem_w_en), 64'(me.w_en));
                check_eq("mem_r_en", 64'(o_mem_r_en), 64'(me.r_en));
                if (k < mdly) @(negedge clk);
            end
            d_mem_ready  = 1'b1;
            d_mem_rvalid = early_rv;
            @(negedge clk);
            d_mem_ready  = 1'b0;
            d_mem_rvalid = 1'b0;
            check_eq("mem_valid_drop", 64'(o_mem_valid), 64'd0);
            check_eq("mem_mask_idle", 64'(o_mem_mask), 64'd0);
            if (early_rv) check_eq("early_rvalid_ignored", 64'(o_rsp_valid), 64'd0);
            d_mem_rvalid = 1'b1;
            @(negedge clk);
            d_mem_rvalid = 1'b0;
        end else begin
            check_eq("mis_no_mem", 64'(o_mem_valid), 64'd0);
        end
        check_eq("rsp_valid_lat", 64'(o_rsp_valid), 64'd1);
        re = rsp_q.pop_front();
        for (int k = 0; k <= rdly; k++) begin
            check_eq("rsp_valid_hold", 64'(o_rsp_valid), 64'd1);
            check_eq("rsp_rdata", o_rsp_rdata, re.rdata);
            check_eq("rsp_misalign", 64'(o_rsp_misalign), 64'(re.mis));
            check_eq("mem_quiet", 64'(o_mem_valid), 64'd0);
            if (k < rdly) @(negedge clk);
        end
        d_rsp_ready = 1'b1;
        @(negedge clk);
        d_rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", 64'(o_rsp_valid), 64'd0);
        check_eq("req_ready_back", 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit          w64, st, uns;
        logic [1:0]  sz;
        logic [63:0] a, wd, mr;

        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 64'(i32.req_ready), 64'd0);
        check_eq("rst_mem_valid", 64'(i32.mem_valid | i64.mem_valid), 64'd0);
        check_eq("rst_rsp_valid", 64'(i32.rsp_valid | i64.rsp_valid), 64'd0);
        check_eq("rst_rdata", {i32.rsp_rdata, 32'h0} | i64.rsp_rdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_ready32", 64'(i32.req_ready), 64'd1);
        check_eq("post_rst_req_ready64", 64'(i64.req_ready), 64'd1);

        // Directed 32-bit cases
        do_op(0, 1, 0, 2'd0, 64'h8000_0003, 64'h1234_5678, 64'h0, 0, 0, 0);
        do_op(0, 0, 0, 2'd1, 64'h8000_0002, 64'h0, 64'h8001_BEEF, 0, 0, 0);
        do_op(0, 0, 1, 2'd1, 64'h8000_0002, 64'h0, 64'h8001_BEEF, 0, 0, 0);
        do_op(0, 0, 0, 2'd2, 64'h8000_0002, 64'h0, 64'hDEAD_BEEF, 0, 0, 0);
        do_op(0, 1, 0, 2'd2, 64'h8000_0004, 64'hCAFE_F00D, 64'hFFFF_FFFF, 3, 2, 0);
        do_op(0, 0, 0, 2'd0, 64'h8000_0001, 64'h0, 64'h0000_8000, 1, 1, 1);
        do_op(0, 0, 0, 2'd3, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0);

        // Directed 64-bit cases
        do_op(1, 0, 0, 2'd3, 64'h0000_0000_8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_op(1, 0, 0, 2'd2, 64'h0000_0000_8000_0004, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_op(1, 0, 0, 2'd2, 64'h0000_0000_8000_0000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_op(1, 1, 0, 2'd1, 64'h0000_0000_8000_0006, 64'h1111_2222_3333_ABCD, 64'h0, 1, 0, 0);
        do_op(1, 0, 0, 2'd3, 64'h0000_0000_8000_0004, 64'h0, 64'h0, 0, 1, 0);

        // Reset while waiting for the memory response; a late rvalid must be dropped
        @(negedge clk);
        sel64 = 1'b0; d_store = 1'b0; d_size = 2'd2; d_uns = 1'b0;
        d_addr = 64'h8000_0010; d_req_valid = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0;
        d_mem_ready = 1'b1;
        @(negedge clk);
        d_mem_ready = 1'b0;
        check_eq("wait_mem_valid", 64'(o_mem_valid), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("midrst_mem_valid", 64'(o_mem_valid), 64'd0);
        check_eq("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_eq("midrst_req_ready", 64'(o_req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        d_mem_rvalid = 1'b1;
        d_mem_r = 64'h5555_5555;
        @(negedge clk);
        d_mem_rvalid = 1'b0;
        check_eq("late_rvalid_rsp", 64'(o_rsp_valid), 64'd0);
        check_eq("late_rvalid_ready", 64'(o_req_ready), 64'd1);
        @(negedge clk);
        check_eq("late_rvalid_rsp2", 64'(o_rsp_valid), 64'd0);
        check_eq("late_rvalid_mem", 64'(o_mem_valid), 64'd0);

        // Randomised mix on both widths
        for (int t = 0; t < 16; t++) begin
            w64 = ($urandom_range(0, 1) == 1);
            st  = ($urandom_range(0, 1) == 1);
            uns = ($urandom_range(0, 1) == 1);
            sz  = w64 ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
            a   = {32'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 15))};
            wd  = {32'($urandom), 32'($urandom)};
            mr  = {32'($urandom), 32'($urandom)};
            do_op(w64, st, uns, sz, a, wd, mr, $urandom_range(0, 2), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0));
        end

        check_eq("sb_mem_empty", 64'(mem_q.size()), 64'd0);
        check_eq("sb_rsp_empty", 64'(rsp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
